// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, state encoding and the parity helper
// used by both the transmit framer and the receiver state machine.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned CNT_BITS   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_framer_buf.sv
// One-entry holding buffer in front of the framer; parity is computed on accept
// so the framer never needs the raw byte and the parity at the same time.
module uart_tx_framer_buf
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] Din,
  input  logic                 Din_valid,
  input  logic                 take,
  output logic                 Din_ready,
  output logic                 full,
  output logic [DATA_BITS-1:0] data,
  output logic                 par
);

  assign Din_ready = !full;

  // take only happens while full, so it can never collide with a handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
      par  <= 1'b0;
    end else if (take) begin
      full <= 1'b0;
    end else if (Din_valid && !full) begin
      full <= 1'b1;
      data <= Din;
      par  <= parity_of(Din, PARITY_ODD);
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 8 data bits LSB first, parity, stop, paced by
// an external baud enable, with a one-byte holding buffer for back-to-back frames.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [DATA_BITS-1:0] Din,
  input  logic                 Din_valid,
  output logic                 Din_ready,
  input  logic                 Mreset,
  output logic                 Tx_out,
  output logic                 busy,
  output logic                 done
);

  uart_state_t          state, state_n;
  logic [CNT_BITS-1:0]  cnt, cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 tx_n, done_n;
  logic                 take;
  logic                 buf_full, buf_par;
  logic [DATA_BITS-1:0] buf_data;

  uart_tx_framer_buf #(
    .PARITY_ODD(PARITY_ODD)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .Din      (Din),
    .Din_valid(Din_valid),
    .take     (take),
    .Din_ready(Din_ready),
    .full     (buf_full),
    .data     (buf_data),
    .par      (buf_par)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    par_n   = par;
    tx_n    = Tx_out;
    done_n  = 1'b0;
    take    = 1'b0;
    // Abort ignores ena and is a no-op in IDLE so it cannot block a pending start
    if (Mreset && state != ST_IDLE) begin
      state_n = ST_IDLE;
      tx_n    = 1'b1;
    end else if (ena) begin
      unique case (state)
        ST_IDLE: begin
          if (buf_full) begin
            take    = 1'b1;
            state_n = ST_START;
            shreg_n = buf_data;
            par_n   = buf_par;
            tx_n    = 1'b0;
          end
        end
        ST_START: begin
          state_n = ST_DATA;
          cnt_n   = '0;
          tx_n    = shreg[0];
        end
        ST_DATA: begin
          if (cnt == CNT_BITS'(DATA_BITS - 1)) begin
            state_n = ST_PARITY;
            cnt_n   = '0;
            tx_n    = par;
          end else begin
            cnt_n   = cnt + CNT_BITS'(1);
            shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
            tx_n    = shreg[1];
          end
        end
        ST_PARITY: begin
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end
        ST_STOP: begin
          done_n = 1'b1;
          if (buf_full) begin
            take    = 1'b1;
            state_n = ST_START;
            shreg_n = buf_data;
            par_n   = buf_par;
            tx_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          tx_n    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      Tx_out <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= shreg_n;
      par    <= par_n;
      Tx_out <= tx_n;
      done   <= done_n;
    end
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter PARITY_ODD, default 0; 0 = even parity bit, 1 = odd parity bit.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ena  input  1  baud-rate enable, one clk wide per bit period; the frame advances only on clk edges where ena=1.
REQ-005 Din  input  8  byte to transmit; sampled when Din_valid and Din_ready are both 1.
REQ-006 Din_valid  input  1  upstream offers Din.
REQ-007 Din_ready  output  1  holding buffer empty; a byte is accepted this cycle if Din_valid=1.
REQ-008 Mreset  input  1  abort request from the far-end receiver.
REQ-009 Tx_out  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  a frame is in progress, i.e. state is not IDLE.
REQ-011 done  output  1  one-clk pulse when a stop bit completes normally.

Function
REQ-012 Frame order: start(0), D0..D7 (LSB first), parity, stop(1); 11 bit periods total.
REQ-013 Parity bit SHALL be XOR(Din[7:0]) XOR PARITY_ODD, computed when the byte is accepted.
REQ-014 Holding buffer: 1 entry; Din_ready = !buf_full; a handshake sets buf_full on the same edge.
REQ-015 FSM states: IDLE, START, DATA (3-bit bit counter 0..7), PARITY, STOP.
REQ-016 IDLE -> START on an ena edge with buf_full=1; on that edge the buffer moves into the shift register, buf_full clears, and Tx_out=0.
REQ-017 START -> DATA, DATA(bit n) -> DATA(bit n+1), DATA(bit 7) -> PARITY, PARITY -> STOP; each transition occurs on an ena edge only; Tx_out takes the new state's bit on the same edge.
REQ-018 STOP -> START on an ena edge if buf_full=1 (back-to-back, no idle gap); otherwise STOP -> IDLE. done=1 for exactly that clk.
REQ-019 ena=0: state, counter, shift register and Tx_out hold; buffer handshakes are still accepted.
REQ-020 Mreset=1 on any clk edge, regardless of ena: go to IDLE, Tx_out=1, drop the in-flight frame, no done pulse; the holding buffer is retained.
REQ-021 Mreset and a buffer handshake in the same cycle: both take effect.
REQ-022 Mreset in IDLE: no effect.
REQ-023 Latency: the start bit appears on the first ena edge after the accept edge (same-edge accept does not count).

Reset
REQ-024 reset=1 asynchronously forces: state=IDLE, counter=0, shift register=0, buf_full=0, Tx_out=1, busy=0, done=0, Din_ready=1.
REQ-025 Reset mid-frame: Tx_out returns high immediately; the frame and buffered byte are discarded.
REQ-026 After reset deasserts, operation resumes on the next clk edge.

Structure
REQ-027 A shared uart_pkg SHALL hold the state encoding, FRAME_BITS=11 and DATA_BITS=8; the receiver state machine uses the same package.
REQ-028 Sub-module uart_baud_gen (divider producing ena from clk) SHALL be instantiated outside this block and not inside it.
REQ-029 Single always_ff for state/datapath plus combinational next-state; no latches.

Verification
REQ-030 Din=0xA5, PARITY_ODD=0, ena every 16 clk -> Tx_out per period: 0,1,0,1,0,0,1,0,1,0,1; one done pulse; busy high for 11 periods.
REQ-031 Back-to-back: 0x01 accepted, then 0x80 accepted during frame 1 -> frames contiguous, no idle period; Din_ready low from 0x80 accept until frame 2 START.
REQ-032 Mreset pulse during DATA bit 3 of 0x3C, with 0x55 buffered -> Tx_out=1 next edge, no done; 0x55 frame starts on the following ena.
REQ-033 Async reset asserted between clk edges during PARITY -> Tx_out=1, Din_ready=1 before the next clk edge; no frame after release until a new handshake.
REQ-034 ena held low for 100 clk mid-frame -> Tx_out constant; the frame completes correctly once ena resumes.
REQ-035 PARITY_ODD=1, Din=0x00 -> parity bit 1; Din=0x07 -> parity bit 0.
